// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that drives it.
package mdu_pkg;

    localparam int MDU_OP_W = 2;

    typedef enum logic [MDU_OP_W-1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step on the MDU accumulator: shift-add multiply, or restoring
// shift-subtract divide when MULT_DIV_UNIT_DIV_EN is defined.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
`ifdef MULT_DIV_UNIT_DIV_EN
    input  logic               div_i,
`endif
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [2*WIDTH-1:0] mul_nxt;

    // Upper half gains the multiplicand when the current multiplier LSB is set.
    assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    assign mul_nxt = {sum, acc_i[WIDTH-1:1]};

`ifdef MULT_DIV_UNIT_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic [2*WIDTH-1:0] div_nxt;

    assign rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, opnd_i};

    always_comb begin
        div_nxt = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) div_nxt = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end

    assign acc_o = div_i ? div_nxt : mul_nxt;
`else
    assign acc_o = mul_nxt;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO.
// Divide support is built only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         state_q;
    mdu_op_t            op_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_init, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_init, hi_q, lo_q, mag_a, mag_b;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_lo_q, busy_q, done_q, div_zero_q;
    logic               sgn, dz_start, go_fix;

    assign sgn   = op_is_signed(op);
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    assign prod  = neg_lo_q ? -acc_q : acc_q;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic             neg_hi_q, dz_q;
    logic [WIDTH-1:0] quo, rem;

    assign dz_start  = op[1] && (b == '0);
    assign go_fix    = dz_start;
    assign opnd_init = op[1] ? mag_b : mag_a;
    assign quo       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem       = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // A zero divisor parks the raw dividend in the accumulator so FIX can copy it to HI.
    always_comb begin
        acc_init = {{WIDTH{1'b0}}, mag_b};
        if (dz_start)   acc_init = {{WIDTH{1'b0}}, a};
        else if (op[1]) acc_init = {{WIDTH{1'b0}}, mag_a};
    end
`else
    assign dz_start  = 1'b0;
    assign go_fix    = op[1];
    assign opnd_init = mag_a;
    assign acc_init  = {{WIDTH{1'b0}}, mag_b};
`endif

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
`ifdef MULT_DIV_UNIT_DIV_EN
        .div_i  (op_q[1]),
`endif
        .acc_o  (acc_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= MULT;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_lo_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        op_q       <= mdu_op_t'(op);
                        acc_q      <= acc_init;
                        opnd_q     <= opnd_init;
                        cnt_q      <= '0;
                        neg_lo_q   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        div_zero_q <= dz_start;
                        busy_q     <= 1'b1;
                        state_q    <= go_fix ? FIX : BUSY;
`ifdef MULT_DIV_UNIT_DIV_EN
                        neg_hi_q   <= sgn && a[WIDTH-1];
                        dz_q       <= dz_start;
`endif
                    end else begin
                        state_q <= IDLE;
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    if (op_q inside {MULT, MULTU}) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
`ifdef MULT_DIV_UNIT_DIV_EN
                    else if (dz_q) begin
                        hi_q <= acc_q[WIDTH-1:0];
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_out = state_q;

endmodule
